// File: rtl/fetch_unit_pkg.sv
// Shared MIPS front-end constants: reset vector, word size, fetch FSM encodings
// and the opcode/funct values the control decoder also keys on.
package fetch_unit_pkg;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;
   localparam int unsigned WORD_BYTES       = 4;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_ISSUE = 2'd1,
      ST_HALT  = 2'd2
   } fetch_state_t;

   localparam logic [5:0] OP_J         = 6'd2;
   localparam logic [5:0] OP_JAL       = 6'd3;
   localparam logic [5:0] OP_BEQ       = 6'd4;
   localparam logic [5:0] OP_BNE       = 6'd5;
   localparam logic [5:0] FUNC_SYSCALL = 6'h0c;

endpackage

// File: rtl/fetch_unit_fetch_pc.sv
// Program counter register with next-PC selection (sequential or word-aligned redirect).
module fetch_pc
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int unsigned ADDR_W   = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              use_redirect,
   input  logic [ADDR_W-3:0] redirect_word,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_plus4
);

   logic [ADDR_W-1:0] pc_next;

   // Wraps modulo 2^ADDR_W by construction of the adder width.
   assign pc_plus4 = pc + ADDR_W'(WORD_BYTES);
   assign pc_next  = use_redirect ? {redirect_word, 2'b00} : pc_plus4;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         pc <= RESET_PC[ADDR_W-1:0];
      else if (load)
         pc <= pc_next;
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: memory handshake, instruction register and stall/redirect/syscall FSM.
// Optional FETCH_ALIGN_CHECK_EN halts on a misaligned redirect and raises addrErr.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int unsigned ADDR_W   = 32
) (
   input  logic              clk,
   input  logic              reset,
   output logic              imemReq,
   output logic [ADDR_W-1:0] imemAddr,
   input  logic              imemReady,
   input  logic [31:0]       imemData,
   output logic [31:0]       instr,
   output logic [5:0]        opcode,
   output logic [5:0]        funcCode,
   output logic              instrValid,
   output logic [ADDR_W-1:0] pcOut,
   output logic [ADDR_W-1:0] pcPlus4,
   input  logic              stall,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirectPc,
   input  logic              syscall,
   input  logic              resume,
`ifdef FETCH_ALIGN_CHECK_EN
   output logic              addrErr,
`endif
   output logic              halted
);

   fetch_state_t      state, state_next;
   logic              pc_load, use_redirect, instr_load, err_set, align_fault;
   logic [ADDR_W-1:0] pc;

   fetch_pc #(.RESET_PC(RESET_PC), .ADDR_W(ADDR_W)) u_pc (
      .clk          (clk),
      .reset        (reset),
      .load         (pc_load),
      .use_redirect (use_redirect),
      .redirect_word(redirectPc[ADDR_W-1:2]),
      .pc           (pc),
      .pc_plus4     (pcPlus4)
   );

`ifdef FETCH_ALIGN_CHECK_EN
   assign align_fault = redirect && (redirectPc[1:0] != 2'b00);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         addrErr <= 1'b0;
      else if (err_set)
         addrErr <= 1'b1;
      else if (state == ST_HALT && resume)
         addrErr <= 1'b0;
   end
`else
   logic unused_low_bits;
   assign align_fault     = 1'b0;
   assign unused_low_bits = ^redirectPc[1:0];
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_FETCH;
         instr <= 32'h0;
      end else begin
         state <= state_next;
         if (instr_load)
            instr <= imemData;
      end
   end

   always_comb begin
      state_next   = state;
      pc_load      = 1'b0;
      use_redirect = 1'b0;
      instr_load   = 1'b0;
      err_set      = 1'b0;
      unique case (state)
         ST_FETCH: begin
            if (imemReady) begin
               instr_load = 1'b1;
               state_next = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (syscall) begin
               state_next = ST_HALT;
            end else if (!stall) begin
               if (align_fault) begin
                  err_set    = 1'b1;
                  state_next = ST_HALT;
               end else begin
                  pc_load      = 1'b1;
                  use_redirect = redirect;
                  state_next   = ST_FETCH;
               end
            end
         end
         ST_HALT: begin
            if (resume) begin
               pc_load    = 1'b1;
               state_next = ST_FETCH;
            end
         end
         default: state_next = ST_FETCH;
      endcase
   end

   // Gating with reset drops an in-flight request the moment reset asserts.
   assign imemReq    = (state == ST_FETCH) && !reset;
   assign imemAddr   = pc;
   assign pcOut      = pc;
   assign instrValid = (state == ST_ISSUE);
   assign halted     = (state == ST_HALT);
   assign opcode     = instr[31:26];
   assign funcCode   = instr[5:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit, plus hand sequences for wrap,
// misaligned redirect (FETCH_ALIGN_CHECK_EN aware) and async reset mid-fetch.
module tb_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0040_0000;

   logic        clk, reset;
   logic        imemReq, imemReady, instrValid, stall, redirect, syscall, resume, halted;
   logic [31:0] imemAddr, imemData, instr, pcOut, pcPlus4, redirectPc;
   logic [5:0]  opcode, funcCode;
`ifdef FETCH_ALIGN_CHECK_EN
   logic        addrErr;
`endif

   int checks = 0;
   int errors = 0;

   fetch_unit dut (
      .clk(clk), .reset(reset),
      .imemReq(imemReq), .imemAddr(imemAddr), .imemReady(imemReady), .imemData(imemData),
      .instr(instr), .opcode(opcode), .funcCode(funcCode), .instrValid(instrValid),
      .pcOut(pcOut), .pcPlus4(pcPlus4), .stall(stall), .redirect(redirect),
      .redirectPc(redirectPc), .syscall(syscall), .resume(resume),
`ifdef FETCH_ALIGN_CHECK_EN
      .addrErr(addrErr),
`endif
      .halted(halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        ready;
      logic [31:0] data;
      logic        stl, redir;
      logic [31:0] rpc;
      logic        sys, res;
      logic        expReq, expValid, expHalted;
      logic [31:0] expInstr, expPc;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic ready, logic [31:0] data, logic stl, logic redir,
                               logic [31:0] rpc, logic sys, logic res, logic eReq,
                               logic eValid, logic eHalt, logic [31:0] eInstr, logic [31:0] ePc);
      vec_t v;
      v.ready = ready; v.data = data; v.stl = stl; v.redir = redir; v.rpc = rpc;
      v.sys = sys; v.res = res; v.expReq = eReq; v.expValid = eValid;
      v.expHalted = eHalt; v.expInstr = eInstr; v.expPc = ePc;
      return v;
   endfunction

   task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      imemReady  = v.ready;
      imemData   = v.data;
      stall      = v.stl;
      redirect   = v.redir;
      redirectPc = v.rpc;
      syscall    = v.sys;
      resume     = v.res;
   endtask

   task automatic checkOutput(input string tag, input vec_t v);
      checkVal({tag, ".imemReq"},    32'(imemReq),    32'(v.expReq));
      checkVal({tag, ".imemAddr"},   imemAddr,        v.expPc);
      checkVal({tag, ".instrValid"}, 32'(instrValid), 32'(v.expValid));
      checkVal({tag, ".halted"},     32'(halted),     32'(v.expHalted));
      checkVal({tag, ".instr"},      instr,           v.expInstr);
      checkVal({tag, ".opcode"},     32'(opcode),     32'(v.expInstr[31:26]));
      checkVal({tag, ".funcCode"},   32'(funcCode),   32'(v.expInstr[5:0]));
      checkVal({tag, ".pcOut"},      pcOut,           v.expPc);
      checkVal({tag, ".pcPlus4"},    pcPlus4,         v.expPc + 32'd4);
   endtask

   task automatic idle();
      applyStimulus(mk(0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 32'h0, 32'h0));
   endtask

   localparam logic [31:0] D1 = 32'h2008_0005, D2 = 32'h0000_000C, D3 = 32'h8C09_0004;
   localparam logic [31:0] D4 = 32'h0109_5020, D5 = 32'h0800_0000, D6 = 32'h03E0_0008;

   initial begin
      //               rdy data stl rd  rpc           sys res  req val hlt instr pc
      vecs.push_back(mk(1, D1, 0, 0, 32'h0,          0, 0,   1, 0, 0, 32'h0, 32'h0040_0000));
      vecs.push_back(mk(0, 0,  0, 0, 32'h0,          0, 0,   0, 1, 0, D1,    32'h0040_0000));
      vecs.push_back(mk(1, D2, 0, 0, 32'h0,          0, 0,   1, 0, 0, D1,    32'h0040_0004));
      vecs.push_back(mk(0, 0,  0, 0, 32'h0,          1, 0,   0, 1, 0, D2,    32'h0040_0004));
      vecs.push_back(mk(1, D6, 0, 1, 32'h0040_0200,  0, 0,   0, 0, 1, D2,    32'h0040_0004));
      vecs.push_back(mk(0, 0,  0, 0, 32'h0,          0, 1,   0, 0, 1, D2,    32'h0040_0004));
      vecs.push_back(mk(0, 0,  0, 0, 32'h0,          0, 0,   1, 0, 0, D2,    32'h0040_0008));
      vecs.push_back(mk(0, 0,  0, 1, 32'h0040_0200,  1, 1,   1, 0, 0, D2,    32'h0040_0008));
      vecs.push_back(mk(0, 0,  0, 0, 32'h0,          0, 0,   1, 0, 0, D2,    32'h0040_0008));
      vecs.push_back(mk(1, D3, 0, 0, 32'h0,          0, 0,   1, 0, 0, D2,    32'h0040_0008));
      vecs.push_back(mk(0, 0,  1, 1, 32'h0040_0100,  0, 0,   0, 1, 0, D3,    32'h0040_0008));
      vecs.push_back(mk(1, D6, 1, 0, 32'h0,          0, 0,   0, 1, 0, D3,    32'h0040_0008));
      vecs.push_back(mk(0, 0,  1, 0, 32'h0,          0, 0,   0, 1, 0, D3,    32'h0040_0008));
      vecs.push_back(mk(0, 0,  1, 0, 32'h0,          0, 0,   0, 1, 0, D3,    32'h0040_0008));
      vecs.push_back(mk(0, 0,  1, 0, 32'h0,          0, 0,   0, 1, 0, D3,    32'h0040_0008));
      vecs.push_back(mk(0, 0,  0, 0, 32'h0,          0, 0,   0, 1, 0, D3,    32'h0040_0008));
      vecs.push_back(mk(1, D4, 0, 0, 32'h0,          0, 0,   1, 0, 0, D3,    32'h0040_000C));
      vecs.push_back(mk(0, 0,  0, 1, 32'h0040_0100,  0, 0,   0, 1, 0, D4,    32'h0040_000C));
      vecs.push_back(mk(1, D5, 0, 0, 32'h0,          0, 0,   1, 0, 0, D4,    32'h0040_0100));
      vecs.push_back(mk(0, 0,  0, 0, 32'h0,          0, 0,   0, 1, 0, D5,    32'h0040_0100));
      vecs.push_back(mk(0, 0,  0, 0, 32'h0,          0, 0,   1, 0, 0, D5,    32'h0040_0104));

      reset = 1'b1;
      idle();
      @(negedge clk);
      checkVal("reset.imemReq",    32'(imemReq),    32'h0);
      checkVal("reset.instrValid", 32'(instrValid), 32'h0);
      checkVal("reset.halted",     32'(halted),     32'h0);
      checkVal("reset.pcOut",      pcOut,           RST_PC);
      checkVal("reset.instr",      instr,           32'h0);
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         applyStimulus(vecs[i]);
         #1;
         checkOutput($sformatf("vec%0d", i), vecs[i]);
      end

      // Wrap: redirect to the top word, then advance past it.
      @(negedge clk); idle(); imemReady = 1'b1; imemData = D6;
      @(negedge clk); idle(); redirect = 1'b1; redirectPc = 32'hFFFF_FFFC;
      #1 checkVal("wrap.issueValid", 32'(instrValid), 32'h1);
      @(negedge clk); idle(); imemReady = 1'b1; imemData = D1;
      #1 checkVal("wrap.topAddr", imemAddr, 32'hFFFF_FFFC);
      checkVal("wrap.pcPlus4", pcPlus4, 32'h0);
      @(negedge clk); idle();
      @(negedge clk); idle();
      #1 checkVal("wrap.nextAddr", imemAddr, 32'h0);
      checkVal("wrap.nextReq", 32'(imemReq), 32'h1);

      // Misaligned redirect from pc = 0.
      imemReady = 1'b1; imemData = D4;
      @(negedge clk); idle(); redirect = 1'b1; redirectPc = 32'h0040_0102;
      @(negedge clk); idle();
      #1;
`ifdef FETCH_ALIGN_CHECK_EN
      checkVal("align.addrErr", 32'(addrErr), 32'h1);
      checkVal("align.halted",  32'(halted),  32'h1);
      checkVal("align.pcHeld",  pcOut,        32'h0);
      resume = 1'b1;
      @(negedge clk); idle();
      #1 checkVal("align.resumeAddr", imemAddr, 32'h4);
      checkVal("align.errCleared", 32'(addrErr), 32'h0);
`else
      checkVal("align.masked", imemAddr,       32'h0040_0100);
      checkVal("align.halted", 32'(halted),    32'h0);
      checkVal("align.req",    32'(imemReq),   32'h1);
`endif

      // Async reset mid-fetch, with resume also asserted.
      @(negedge clk); idle(); resume = 1'b1;
      #2 reset = 1'b1;
      #1;
      checkVal("asyncRst.imemReq", 32'(imemReq), 32'h0);
      checkVal("asyncRst.pcOut",   pcOut,         RST_PC);
      checkVal("asyncRst.halted",  32'(halted),   32'h0);
      @(negedge clk); idle(); reset = 1'b0;
      #1 checkVal("asyncRst.reqAfter", 32'(imemReq), 32'h1);
      checkVal("asyncRst.addrAfter", imemAddr, RST_PC);

      $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
